cp0_exc_ctrl: RTL

- Parametrised CP0 register file and precise-exception controller for the MIPS pipeline. Sits at the E/M boundary.
- Prioritises a per-instruction exception request vector, commits EPC/Cause/Status/BadVAddr updates, and drives the pipeline flush and redirect PC.
- Generalises the previous unit:
  - configurable interrupt line count, TLB depth and Count divider;
  - synchronised external interrupts;
  - a real timer interrupt (Cause.TI / IP7);
  - stall-aware commit;
  - MIPS EXL-nesting rules.

---
 rtl/cp0_pkg.sv | 73 +++++++
 rtl/cp0_timer.sv | 53 +++++
 rtl/cp0_exc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, exception request
// bit indices and Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [2:0] SEL_0     = 3'd0;
    localparam logic [2:0] SEL_EBASE = 3'd1;

    typedef enum logic [4:0] {
        EC_INT  = 5'd0,
        EC_MOD  = 5'd1,
        EC_TLBL = 5'd2,
        EC_TLBS = 5'd3,
        EC_ADEL = 5'd4,
        EC_ADES = 5'd5,
        EC_SYS  = 5'd8,
        EC_BP   = 5'd9,
        EC_RI   = 5'd10,
        EC_OV   = 5'd12,
        EC_TR   = 5'd13
    } exccode_e;

    // Request vector, highest priority at bit 0. EXC_D_REFILL is not a request
    // of its own: it marks a TLBL_D/TLBS request as a refill (else invalid).
    localparam int EXC_W             = 14;
    localparam int EXC_ADEL_I        = 0;
    localparam int EXC_TLBL_I_REFILL = 1;
    localparam int EXC_TLBL_I_INV    = 2;
    localparam int EXC_RI            = 3;
    localparam int EXC_SYS           = 4;
    localparam int EXC_BP            = 5;
    localparam int EXC_OV            = 6;
    localparam int EXC_TR            = 7;
    localparam int EXC_ADEL_D        = 8;
    localparam int EXC_ADES          = 9;
    localparam int EXC_TLBL_D        = 10;
    localparam int EXC_TLBS          = 11;
    localparam int EXC_MOD           = 12;
    localparam int EXC_D_REFILL      = 13;

    localparam logic [EXC_W-1:0] EXC_REQ_MASK = ~(14'd1 << EXC_D_REFILL);

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_ERL   = 2;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV   = 22;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IV     = 23;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
    localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;
    localparam logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200;
    localparam logic [31:0] VEC_GEN_OFF  = 32'h0000_0180;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every COUNT_DIV clocks and
// timer_int latches when Count steps onto Compare until Compare is rewritten.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [31:0]      count_inc;

    assign tick      = (div == DIV_LAST);
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div   <= '0;
            end else if (tick) begin
                count <= count_inc;
                div   <= '0;
            end else begin
                div <= div + 1'b1;
            end

            // Only a real increment onto Compare raises the interrupt.
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (!count_we && tick && (count_inc == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and precise-exception controller at the E/M boundary:
// prioritises exception requests, commits EPC/Cause/Status/BadVAddr, drives flush and redirect.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          TLB_ENTRIES = 16,
    parameter int          HW_INT_NUM  = 6,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EBASE_RST   = 32'h8000_0000,
    parameter logic [31:0] PRID_VAL    = 32'h0001_8003,
    localparam int         IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  pc_valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_ds_i,
    input  logic [EXC_W-1:0]      exc_req_i,
    input  logic                  eret_i,
    input  logic [31:0]           bad_vaddr_i,
    input  logic                  mtc0_we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            sel_i,
    input  logic [31:0]           wdata_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    output logic [31:0]           rdata_o,
    output logic                  flush_o,
    output logic [31:0]           exc_pc_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o,
    output logic [IDX_W-1:0]      random_o,
    output logic                  timer_int_o
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    logic [31:0]           status;
    logic [31:0]           epc;
    logic [31:0]           badvaddr;
    logic [31:0]           ebase;
    logic                  cause_bd;
    logic                  cause_iv;
    logic [1:0]            cause_ip_sw;
    logic [4:0]            cause_exc;
    logic [31:0]           cause;
    logic [7:0]            ip;
    logic [IDX_W-1:0]      random;
    logic [IDX_W-1:0]      wired;
    logic [HW_INT_NUM-1:0] int_s1;
    logic [HW_INT_NUM-1:0] int_s2;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;

    logic        int_pend;
    logic        exc_any;
    logic        exc_take;
    logic        commit_exc;
    logic        commit_eret;
    exccode_e    exc_code;
    logic        bad_from_pc;
    logic        bad_from_data;
    logic        refill;
    logic [31:0] vec_base;
    logic [31:0] vec_off;

    logic mtc0_ok;
    logic wr_sel0;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic wr_count;
    logic wr_compare;
    logic wr_wired;
    logic wr_ebase;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_s1 <= '0;
            int_s2 <= '0;
        end else begin
            int_s1 <= int_i;
            int_s2 <= int_s1;
        end
    end

    // IP7 is shared between the top external line (when present) and the timer.
    always_comb begin
        ip = {6'b0, cause_ip_sw};
        for (int i = 0; i < HW_INT_NUM; i++) begin
            ip[2+i] = int_s2[i];
        end
        ip[7] = ip[7] | timer_int;
    end

    always_comb begin
        cause                            = '0;
        cause[CAUSE_BD]                  = cause_bd;
        cause[CAUSE_TI]                  = timer_int;
        cause[CAUSE_IV]                  = cause_iv;
        cause[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    assign int_pend = status[STATUS_IE] & ~status[STATUS_EXL] & ~status[STATUS_ERL]
                    & (|(status[STATUS_IM_HI:STATUS_IM_LO] & ip)) & pc_valid_i;
    assign exc_any  = |(exc_req_i & EXC_REQ_MASK);
    assign exc_take = (int_pend | exc_any) & pc_valid_i;

    assign flush_o     = (exc_take | eret_i) & ~stall_i;
    assign commit_exc  = flush_o & exc_take;
    assign commit_eret = flush_o & ~exc_take & eret_i;

    always_comb begin
        exc_code      = EC_INT;
        bad_from_pc   = 1'b0;
        bad_from_data = 1'b0;
        refill        = 1'b0;
        if (int_pend) begin
            exc_code = EC_INT;
        end else if (exc_req_i[EXC_ADEL_I]) begin
            exc_code    = EC_ADEL;
            bad_from_pc = 1'b1;
        end else if (exc_req_i[EXC_TLBL_I_REFILL]) begin
            exc_code    = EC_TLBL;
            bad_from_pc = 1'b1;
            refill      = 1'b1;
        end else if (exc_req_i[EXC_TLBL_I_INV]) begin
            exc_code    = EC_TLBL;
            bad_from_pc = 1'b1;
        end else if (exc_req_i[EXC_RI]) begin
            exc_code = EC_RI;
        end else if (exc_req_i[EXC_SYS]) begin
            exc_code = EC_SYS;
        end else if (exc_req_i[EXC_BP]) begin
            exc_code = EC_BP;
        end else if (exc_req_i[EXC_OV]) begin
            exc_code = EC_OV;
        end else if (exc_req_i[EXC_TR]) begin
            exc_code = EC_TR;
        end else if (exc_req_i[EXC_ADEL_D]) begin
            exc_code      = EC_ADEL;
            bad_from_data = 1'b1;
        end else if (exc_req_i[EXC_ADES]) begin
            exc_code      = EC_ADES;
            bad_from_data = 1'b1;
        end else if (exc_req_i[EXC_TLBL_D]) begin
            exc_code      = EC_TLBL;
            bad_from_data = 1'b1;
            refill        = exc_req_i[EXC_D_REFILL];
        end else if (exc_req_i[EXC_TLBS]) begin
            exc_code      = EC_TLBS;
            bad_from_data = 1'b1;
            refill        = exc_req_i[EXC_D_REFILL];
        end else if (exc_req_i[EXC_MOD]) begin
            exc_code      = EC_MOD;
            bad_from_data = 1'b1;
        end
    end

    // Refill gets the dedicated vector only when it is not nested inside another handler.
    assign vec_base = status[STATUS_BEV] ? VEC_BEV_BASE : ebase;
    assign vec_off  = (refill && !status[STATUS_EXL]) ? 32'd0 : VEC_GEN_OFF;

    always_comb begin
        if (!exc_take && eret_i) begin
            exc_pc_o = status[STATUS_ERL] ? 32'd0 : epc;
        end else begin
            exc_pc_o = vec_base + vec_off;
        end
    end

    assign mtc0_ok    = mtc0_we_i & ~stall_i & ~flush_o;
    assign wr_sel0    = mtc0_ok & (sel_i == SEL_0);
    assign wr_status  = wr_sel0 & (waddr_i == CP0_STATUS);
    assign wr_cause   = wr_sel0 & (waddr_i == CP0_CAUSE);
    assign wr_epc     = wr_sel0 & (waddr_i == CP0_EPC);
    assign wr_count   = wr_sel0 & (waddr_i == CP0_COUNT);
    assign wr_compare = wr_sel0 & (waddr_i == CP0_COMPARE);
    assign wr_wired   = wr_sel0 & (waddr_i == CP0_WIRED);
    assign wr_ebase   = mtc0_ok & (sel_i == SEL_EBASE) & (waddr_i == CP0_PRID);

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= STATUS_RST;
        end else if (commit_exc) begin
            status[STATUS_EXL] <= 1'b1;
        end else if (commit_eret) begin
            if (status[STATUS_ERL]) begin
                status[STATUS_ERL] <= 1'b0;
            end else begin
                status[STATUS_EXL] <= 1'b0;
            end
        end else if (wr_status) begin
            status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        end
    end

    // EPC/BD keep the outermost fault when an exception nests inside a handler.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc         <= '0;
            cause_bd    <= 1'b0;
            cause_exc   <= '0;
            cause_iv    <= 1'b0;
            cause_ip_sw <= '0;
            badvaddr    <= '0;
        end else if (commit_exc) begin
            if (!status[STATUS_EXL]) begin
                epc      <= in_ds_i ? (pc_i - 32'd4) : pc_i;
                cause_bd <= in_ds_i;
            end
            cause_exc <= exc_code;
            if (bad_from_pc) begin
                badvaddr <= pc_i;
            end else if (bad_from_data) begin
                badvaddr <= bad_vaddr_i;
            end
        end else begin
            if (wr_epc) begin
                epc <= wdata_i;
            end
            if (wr_cause) begin
                cause_iv    <= wdata_i[CAUSE_IV];
                cause_ip_sw <= wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ebase <= EBASE_RST;
        end else if (wr_ebase) begin
            ebase <= (ebase & ~EBASE_WMASK) | (wdata_i & EBASE_WMASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random <= RAND_TOP;
            wired  <= '0;
        end else if (wr_wired) begin
            wired  <= wdata_i[IDX_W-1:0];
            random <= RAND_TOP;
        end else if (random == wired) begin
            random <= RAND_TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    always_comb begin
        rdata_o = '0;
        if (sel_i == SEL_0) begin
            case (raddr_i)
                CP0_RANDOM:   rdata_o = {{(32-IDX_W){1'b0}}, random};
                CP0_WIRED:    rdata_o = {{(32-IDX_W){1'b0}}, wired};
                CP0_BADVADDR: rdata_o = badvaddr;
                CP0_COUNT:    rdata_o = count;
                CP0_COMPARE:  rdata_o = compare;
                CP0_STATUS:   rdata_o = status;
                CP0_CAUSE:    rdata_o = cause;
                CP0_EPC:      rdata_o = epc;
                CP0_PRID:     rdata_o = PRID_VAL;
                default:      rdata_o = '0;
            endcase
        end else if ((sel_i == SEL_EBASE) && (raddr_i == CP0_PRID)) begin
            rdata_o = ebase;
        end
    end

    assign status_o    = status;
    assign cause_o     = cause;
    assign epc_o       = epc;
    assign count_o     = count;
    assign random_o    = random;
    assign timer_int_o = timer_int;

endmodule
